// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop rx synchroniser, mid-bit start validation,
// configurable data width / parity / stop bits, valid/ready word delivery with
// parity, framing and sticky overrun flags.
module uart_rx_param #(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 err_clr,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_HALF  = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_ONE   = BW'(1);
  localparam logic          S_LAST  = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD = 1'(PARITY == 1);
  localparam logic          HAS_PAR = 1'(PARITY != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PAR    = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        c, c_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic                 stop_idx, stop_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 complete;

  logic                 valid_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 parity_err_nxt;
  logic                 frame_err_nxt;
  logic                 overrun_nxt;
  logic                 busy_nxt;

  logic                 rx_meta;
  logic                 rx_s;
  logic [1:0]           sync_vld;
  logic                 armed;

  // Synchroniser and arming; the reset preset of the flops is not evidence of an
  // idle line, so arming waits until rx_s carries a real sample of rx.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      c          <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      valid      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      c          <= c_nxt;
      bit_idx    <= bit_nxt;
      stop_idx   <= stop_nxt;
      shift      <= shift_nxt;
      perr       <= perr_nxt;
      ferr       <= ferr_nxt;
      valid      <= valid_nxt;
      data_out   <= data_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      overrun    <= overrun_nxt;
      busy       <= busy_nxt;
    end
  end

  // Frame sequencing: bit-clock counting and mid-bit / end-of-period sampling.
  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    shift_nxt = shift;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    complete  = 1'b0;

    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_nxt = START;
          c_nxt     = '0;
        end
      end

      START: begin
        if (c == C_HALF) begin
          c_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            perr_nxt  = 1'b0;
            ferr_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          c_nxt = c + C_ONE;
        end
      end

      DATA: begin
        if (c == C_LAST) begin
          c_nxt     = '0;
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          bit_nxt   = bit_idx + B_ONE;
          if (bit_idx == B_LAST) begin
            state_nxt = HAS_PAR ? PAR : STOP;
            stop_nxt  = 1'b0;
          end
        end else begin
          c_nxt = c + C_ONE;
        end
      end

      PAR: begin
        if (c == C_LAST) begin
          c_nxt     = '0;
          perr_nxt  = ((^shift) ^ rx_s) != PAR_ODD;
          state_nxt = STOP;
        end else begin
          c_nxt = c + C_ONE;
        end
      end

      STOP: begin
        if (c == C_LAST) begin
          c_nxt    = '0;
          ferr_nxt = ferr | ~rx_s;
          if (stop_idx == S_LAST) begin
            state_nxt = IDLE;
            complete  = 1'b1;
          end else begin
            stop_nxt = 1'b1;
          end
        end else begin
          c_nxt = c + C_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        c_nxt     = '0;
      end
    endcase
  end

  // Word delivery, handshake and sticky overrun.
  always_comb begin
    valid_nxt      = valid;
    data_nxt       = data_out;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;
    overrun_nxt    = overrun & ~err_clr;
    busy_nxt       = (state_nxt != IDLE);

    if (complete) begin
      if (!valid || ready) begin
        valid_nxt      = 1'b1;
        data_nxt       = shift;
        parity_err_nxt = perr;
        frame_err_nxt  = ferr_nxt;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (valid && ready) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one 8N1 instance and one even-parity instance.
module tb_uart_rx_param;

  localparam int CPP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, rx_p;
  logic       err_clr;
  logic       ready, ready_p;

  logic       valid, valid_p;
  logic [7:0] data_out, data_out_p;
  logic       parity_err, parity_err_p;
  logic       frame_err, frame_err_p;
  logic       overrun, overrun_p;
  logic       busy, busy_p;

  int         n_cmp  = 0;
  int         n_fail = 0;

  int         cap_lat;
  logic [7:0] cap_d;
  logic       cap_pe, cap_fe, cap_vnext;

  always #5 clk = ~clk;

  uart_rx_param #(.CLOCKS_PER_PULSE(CPP), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .err_clr(err_clr), .ready(ready),
    .valid(valid), .data_out(data_out), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_param #(.CLOCKS_PER_PULSE(CPP), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .err_clr(err_clr), .ready(ready_p),
    .valid(valid_p), .data_out(data_out_p), .parity_err(parity_err_p),
    .frame_err(frame_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit to_p, input logic b);
    if (to_p) rx_p = b; else rx = b;
    repeat (CPP) tick();
  endtask

  // par_bit < 0 means no parity bit on the line.
  task automatic send_frame(input bit to_p, input logic [7:0] d, input int par_bit,
                            input logic stop_v);
    drive_bit(to_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
    if (par_bit >= 0) drive_bit(to_p, par_bit[0]);
    drive_bit(to_p, stop_v);
    if (to_p) rx_p = 1'b1; else rx = 1'b1;
    repeat (20) tick();
  endtask

  task automatic capture(input bit to_p);
    cap_lat   = -1;
    cap_d     = 8'h00;
    cap_pe    = 1'b0;
    cap_fe    = 1'b0;
    cap_vnext = 1'b0;
    for (int n = 1; n <= 250; n++) begin
      tick();
      if ((to_p ? valid_p : valid) === 1'b1) begin
        cap_lat = n;
        cap_d   = to_p ? data_out_p : data_out;
        cap_pe  = to_p ? parity_err_p : parity_err;
        cap_fe  = to_p ? frame_err_p : frame_err;
        tick();
        cap_vnext = to_p ? valid_p : valid;
        break;
      end
    end
  endtask

  task automatic rx_frame(input bit to_p, input logic [7:0] d, input int par_bit,
                          input logic stop_v);
    fork
      send_frame(to_p, d, par_bit, stop_v);
      capture(to_p);
    join
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; err_clr = 1'b0; ready = 1'b1; ready_p = 1'b1;
    repeat (3) tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (valid_p !== 1'b0) begin n_fail++; $display("FAIL reset_valid_p: got %b want 0", valid_p); end
    rst = 1'b0;
    repeat (5) tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    rx_frame(1'b0, 8'hA5, -1, 1'b1);
    n_cmp++; if (cap_lat < 154 || cap_lat > 156) begin n_fail++; $display("FAIL basic_latency: got %0d want 154..156", cap_lat); end
    n_cmp++; if (cap_d !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", cap_d); end
    n_cmp++; if (cap_pe !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", cap_pe); end
    n_cmp++; if (cap_fe !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", cap_fe); end
    n_cmp++; if (cap_vnext !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: valid next cycle got %b want 0", cap_vnext); end
  endtask

  task automatic test_parity();
    rx_frame(1'b1, 8'h3C, 0, 1'b1);
    n_cmp++; if (cap_d !== 8'h3C) begin n_fail++; $display("FAIL par_good_data: got %h want 3c", cap_d); end
    n_cmp++; if (cap_pe !== 1'b0) begin n_fail++; $display("FAIL par_good_perr: got %b want 0", cap_pe); end
    rx_frame(1'b1, 8'h3C, 1, 1'b1);
    n_cmp++; if (cap_d !== 8'h3C) begin n_fail++; $display("FAIL par_bad_data: got %h want 3c", cap_d); end
    n_cmp++; if (cap_pe !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr: got %b want 1", cap_pe); end
    n_cmp++; if (cap_fe !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr: got %b want 0", cap_fe); end
  endtask

  task automatic test_frame_err();
    rx_frame(1'b0, 8'h55, -1, 1'b0);
    n_cmp++; if (cap_lat < 0) begin n_fail++; $display("FAIL ferr_valid: got timeout want valid"); end
    n_cmp++; if (cap_d !== 8'h55) begin n_fail++; $display("FAIL ferr_data: got %h want 55", cap_d); end
    n_cmp++; if (cap_fe !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", cap_fe); end
    rx_frame(1'b0, 8'h0F, -1, 1'b1);
    n_cmp++; if (cap_d !== 8'h0F) begin n_fail++; $display("FAIL ferr_next_data: got %h want 0f", cap_d); end
    n_cmp++; if (cap_fe !== 1'b0) begin n_fail++; $display("FAIL ferr_next_flag: got %b want 0", cap_fe); end
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    rx_frame(1'b0, 8'h11, -1, 1'b1);
    n_cmp++; if (cap_d !== 8'h11) begin n_fail++; $display("FAIL ovr_first_data: got %h want 11", cap_d); end
    n_cmp++; if (cap_vnext !== 1'b1) begin n_fail++; $display("FAIL ovr_hold_valid: got %b want 1", cap_vnext); end
    send_frame(1'b0, 8'h22, -1, 1'b1);
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", valid); end
    n_cmp++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL ovr_data_kept: got %h want 11", data_out); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    ready = 1'b1;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: valid got %b want 0", valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    n_cmp++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL ovr_data_after_accept: got %h want 11", data_out); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_glitch();
    logic saw_busy, saw_valid;
    saw_busy  = 1'b0;
    saw_valid = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 4) rx = 1'b1;
      if (busy === 1'b1) saw_busy = 1'b1;
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    n_cmp++; if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", saw_busy); end
    n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_valid: got %b want 0", saw_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy got %b want 0", busy); end
    rx_frame(1'b0, 8'h81, -1, 1'b1);
    n_cmp++; if (cap_d !== 8'h81) begin n_fail++; $display("FAIL glitch_next_data: got %h want 81", cap_d); end
    n_cmp++; if (cap_lat < 154 || cap_lat > 156) begin n_fail++; $display("FAIL glitch_next_latency: got %0d want 154..156", cap_lat); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    logic       saw_busy, saw_valid;
    d = 8'h0A;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
    rx = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
    rst = 1'b0;
    saw_busy  = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy === 1'b1) saw_busy = 1'b1;
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    n_cmp++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_unarmed_busy: got %b want 0", saw_busy); end
    n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_unarmed_valid: got %b want 0", saw_valid); end
    rx = 1'b1;
    repeat (20) tick();
    rx_frame(1'b0, 8'hC3, -1, 1'b1);
    n_cmp++; if (cap_d !== 8'hC3) begin n_fail++; $display("FAIL midrst_next_data: got %h want c3", cap_d); end
    n_cmp++; if (cap_fe !== 1'b0) begin n_fail++; $display("FAIL midrst_next_ferr: got %b want 0", cap_fe); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the next generation of the fixed 8N1 receiver, with configurable data width, parity and stop-bit count, and a metastability synchroniser on rx. It validates the start bit and flags parity, framing and overrun errors. Received words go out on a valid/ready handshake to the FIFO/bus-interface layer. It sits between the FPGA rx pin and the byte consumer.

Parameters:
CLOCKS_PER_PULSE  16  clk cycles per bit period; even, >=4
DATA_BITS  8  data bits per frame, 5..9, sent LSB first
PARITY  0  0 = none, 1 = odd, 2 = even
STOP_BITS  1  stop bits per frame, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx  in  1  asynchronous serial line, idle high
err_clr  in  1  one-cycle pulse; clears sticky overrun
ready  in  1  consumer accepts the word when valid && ready
valid  out  1  data_out/parity_err/frame_err hold an unread word
data_out  out  DATA_BITS  received word
parity_err  out  1  parity mismatch for the held word; 0 when PARITY=0
frame_err  out  1  a stop bit sampled 0 for the held word
overrun  out  1  sticky; a completed frame was dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge): state=IDLE; all counters, shift register and outputs go to 0; the two-flop synchroniser is set to 1; armed=0. Reset takes priority over everything, including mid-frame.
- Synchroniser: rx passes through 2 flops to give rx_s. All logic uses rx_s only.
- armed: set on the first cycle rx_s=1 after reset. IDLE ignores rx_s=0 while armed=0, so a frame already in progress at reset release is never decoded.
- IDLE:
  - rx_s=0 and armed=1 -> START, bit-clock counter c=0.
- START:
  - c increments each cycle.
  - At c==CLOCKS_PER_PULSE/2-1, rx_s is sampled at mid-bit.
  - Sample 0 -> DATA, c=0, bit index=0.
  - Sample 1 -> IDLE (false start, glitch). No outputs change.
- DATA:
  - At c==CLOCKS_PER_PULSE-1, rx_s goes into shift[bit index], c=0.
  - After bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
  - Otherwise c increments.
- PARITY:
  - One bit period; the sample is taken at c==CLOCKS_PER_PULSE-1.
  - perr = (XOR(shift) ^ sample) != (PARITY==1 ? 1 : 0).
- STOP:
  - STOP_BITS bit periods, each sampled at c==CLOCKS_PER_PULSE-1.
  - ferr accumulates as the OR of (sample==0).
  - After the last stop sample -> IDLE on the same edge, so a start bit can be detected on the next cycle.
- Completion (edge of the last stop sample):
  - valid=0, or valid && ready in the same cycle: load data_out=shift, parity_err=perr, frame_err=ferr, and set valid=1.
  - valid=1 && !ready: the new word is dropped, overrun<=1, and the held word and flags are unchanged.
- Handshake:
  - valid && ready with no completion that cycle -> valid<=0. data_out and flags hold their last values.
  - valid is independent of ready. It never drops without acceptance or reset.
- Flags:
  - overrun is cleared only by err_clr or rst.
  - If err_clr coincides with a new overrun, set wins.
  - Errored words are still delivered with valid=1; frame_err does not suppress them.
- Latency: valid rises 155 clk edges after rx falls, for CLOCKS_PER_PULSE=16, 8N1. That is 2 (sync) + 1 (detect) + 8 (half start) + 128 + 16.
- Counters: c width is clog2(CLOCKS_PER_PULSE); bit index width is clog2(DATA_BITS+1). No wrap beyond the terminal count.

Test Plan:
- 8N1, CPP=16, ready=1, send 0xA5 -> valid pulses 1 cycle, 155±1 clks after the falling edge; data_out=0xA5, parity_err=0, frame_err=0.
- PARITY=2, send 0x3C with correct parity bit 0 -> parity_err=0. Resend with parity bit 1 -> data_out=0x3C, parity_err=1.
- Stop bit driven 0 for 0x55 -> data_out=0x55, frame_err=1, valid=1. The next good frame 0x0F clears frame_err.
- ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun=1. Raise ready -> valid drops, overrun stays 1. err_clr pulse -> overrun=0.
- rx low pulse of 5 clks -> busy high then low, valid never asserted, state back to IDLE. A following frame 0x81 is received correctly.
- Assert rst during data bit 4 of a frame with rx held low afterwards -> all outputs 0. No frame is decoded until rx_s=1 is seen; the next full frame 0xC3 is received.
